// File: rtl/mux_xor_frame_scrambler_if.sv
// Bus between a word source and mux_xor_frame_scrambler.
//   master: drives start/mode/key/ch_data/ch_sel/in_valid, receives results
//   slave : the scrambler side
//   start     - one-cycle frame start, samples mode and key
//   mode      - 00 pass, 01 key, 10 LFSR, 11 key and LFSR
//   key       - static key and LFSR seed
//   ch_data   - channel c at [c*WIDTH +: WIDTH]
//   ch_sel    - channel select per accepted word
//   in_valid  - word present this cycle
//   data_out/out_valid     - processed word, one pulse per word
//   check_out/check_valid  - frame XOR check, pulse at frame end
//   busy      - frame in progress
interface mux_xor_frame_scrambler_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int SW = $clog2(CHANNELS);

  logic                      start;
  logic [1:0]                mode;
  logic [WIDTH-1:0]          key;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [SW-1:0]             ch_sel;
  logic                      in_valid;
  logic [WIDTH-1:0]          data_out;
  logic                      out_valid;
  logic [WIDTH-1:0]          check_out;
  logic                      check_valid;
  logic                      busy;

  modport master (
    output start, mode, key, ch_data, ch_sel, in_valid,
    input  data_out, out_valid, check_out, check_valid, busy
  );

  modport slave (
    input  start, mode, key, ch_data, ch_sel, in_valid,
    output data_out, out_valid, check_out, check_valid, busy
  );
endinterface

// File: rtl/mux_xor_frame_scrambler.sv
// Channel mux followed by XOR with a static key and/or an 8-bit Galois LFSR
// keystream, with a running XOR check emitted at the end of each frame.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of mux_xor_frame_scrambler_if (see that file)
module mux_xor_frame_scrambler #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mux_xor_frame_scrambler_if.slave    bus
);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  acc;
  logic [7:0]        lfsr;
  logic [1:0]        mode_r;
  logic [WIDTH-1:0]  key_r;
  logic [WIDTH-1:0]  data_out_r, check_out_r;
  logic              out_valid_r, check_valid_r;
  logic              accept, frame_end;
  logic [7:0]        seed;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  ch_arr [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch_arr[c] = bus.ch_data[c*WIDTH +: WIDTH];
  end

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  assign seed = (8'(bus.key) == 8'h00) ? 8'h01 : 8'(bus.key);

  assign word = ch_arr[bus.ch_sel]
              ^ (mode_r[0] ? key_r : '0)
              ^ (mode_r[1] ? lfsr[WIDTH-1:0] : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // start wins over in_valid in both states; words are only taken in RUN.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (!bus.start && bus.in_valid) begin
          accept = 1'b1;
          if (count == LAST) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      acc           <= '0;
      lfsr          <= 8'h01;
      mode_r        <= 2'b00;
      key_r         <= '0;
      data_out_r    <= '0;
      out_valid_r   <= 1'b0;
      check_out_r   <= '0;
      check_valid_r <= 1'b0;
    end else begin
      out_valid_r   <= 1'b0;
      check_valid_r <= 1'b0;
      if (bus.start) begin
        count  <= '0;
        acc    <= '0;
        mode_r <= bus.mode;
        key_r  <= bus.key;
        lfsr   <= seed;
      end else if (accept) begin
        data_out_r  <= word;
        out_valid_r <= 1'b1;
        acc         <= acc ^ word;
        // keystream advances per word regardless of mode
        lfsr        <= (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
        if (frame_end) begin
          count         <= '0;
          check_out_r   <= acc ^ word;
          check_valid_r <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.check_out   = check_out_r;
  assign bus.check_valid = check_valid_r;
  assign bus.busy        = (state_q == RUN);
endmodule

// File: tb/tb_mux_xor_frame_scrambler.sv
module tb_mux_xor_frame_scrambler;
  localparam int CH = 4, W = 8, FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_xor_frame_scrambler_if #(.CHANNELS(CH), .WIDTH(W)) bus();

  mux_xor_frame_scrambler #(.CHANNELS(CH), .WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- reference model ----------------
  logic [7:0] e_data = 0, e_check = 0;
  bit         e_ov = 0, e_cv = 0, e_busy = 0;
  logic [1:0] m_mode = 0;
  logic [7:0] m_key = 0, m_seed = 1;
  logic [7:0] frame_q[$];

  // keystream value for the n-th word of a frame from a given seed
  function automatic logic [7:0] ks_at(input logic [7:0] s, input int n);
    logic [7:0] l = s;
    for (int i = 0; i < n; i++) l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    return l;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_data = 0; e_check = 0; e_ov = 0; e_cv = 0; e_busy = 0;
        m_mode = 0; m_key = 0; m_seed = 1; frame_q.delete();
      end else begin
        e_ov = 0; e_cv = 0;
        if (bus.start) begin
          e_busy = 1; m_mode = bus.mode; m_key = bus.key;
          m_seed = (bus.key == 0) ? 8'h01 : bus.key;
          frame_q.delete();
        end else if (e_busy && bus.in_valid) begin
          logic [7:0] w, x;
          w = bus.ch_data[int'(bus.ch_sel)*W +: W];
          if (m_mode[0]) w ^= m_key;
          if (m_mode[1]) w ^= ks_at(m_seed, frame_q.size());
          frame_q.push_back(w);
          e_data = w; e_ov = 1;
          if (frame_q.size() == FL) begin
            x = 0;
            foreach (frame_q[i]) x ^= frame_q[i];
            e_check = x; e_cv = 1; e_busy = 0;
            frame_q.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("m_check_valid", 32'(bus.check_valid), 32'(e_cv));
      chk("m_busy", 32'(bus.busy), 32'(e_busy));
      chk("m_check_out", 32'(bus.check_out), 32'(e_check));
      if (e_ov) chk("m_data_out", 32'(bus.data_out), 32'(e_data));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] std_data = 32'h78563412;

  task automatic step(input bit s, input logic [1:0] m, input logic [7:0] k,
                      input logic [31:0] d, input int sel, input bit v);
    bus.start = s; bus.mode = m; bus.key = k; bus.ch_data = d;
    bus.ch_sel = 2'(sel); bus.in_valid = v;
    @(posedge clk); #1;
    bus.start = 0; bus.in_valid = 0;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] k, input logic [31:0] d,
                           input logic [31:0] exp_words, input logic [7:0] exp_chk, input string nm);
    step(1, m, k, d, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, m, k, d, i, 1);
      chk({nm, "_data"}, 32'(bus.data_out), 32'(exp_words[i*8 +: 8]));
      chk({nm, "_ov"}, 32'(bus.out_valid), 1);
    end
    chk({nm, "_cv"}, 32'(bus.check_valid), 1);
    chk({nm, "_chk"}, 32'(bus.check_out), 32'(exp_chk));
    chk({nm, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 0; bus.mode = 0; bus.key = 0; bus.ch_data = 0; bus.ch_sel = 0; bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // idle: in_valid without start is ignored
    step(0, 0, 0, std_data, 1, 1);
    chk("idle_ov", 32'(bus.out_valid), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_data", 32'(bus.data_out), 0);
    chk("idle_chk", 32'(bus.check_out), 0);

    run_frame(2'b00, 8'h00, std_data, 32'h78563412, 8'h08, "pass");
    // back-to-back start right after the frame-end pulse
    run_frame(2'b01, 8'hFF, std_data, 32'h87A9CBED, 8'h08, "key");
    run_frame(2'b10, 8'h00, 32'h0, 32'h2E5CB801, 8'hCB, "lfsr");

    // gapped frame, mode 11
    step(1, 2'b11, 8'h5A, std_data, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 8'h5A, std_data, i, 1);
      step(0, 2'b11, 8'h5A, std_data, i, 0);
      chk("gap_ov", 32'(bus.out_valid), 0);
    end
    chk("gap_chk_held", 32'(bus.check_valid), 0);

    // abort after two words
    step(1, 2'b00, 8'h00, std_data, 0, 0);
    step(0, 0, 0, std_data, 0, 1);
    step(0, 0, 0, std_data, 1, 1);
    step(1, 2'b00, 8'h00, std_data, 2, 1);
    chk("abort_cv", 32'(bus.check_valid), 0);
    chk("start_drop_ov", 32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, std_data, 3 - i, 1);
    chk("abort_fresh_cv", 32'(bus.check_valid), 1);
    chk("abort_fresh_chk", 32'(bus.check_out), 8'h08);

    // async reset mid-frame
    step(1, 2'b10, 8'h00, 32'h0, 0, 0);
    step(0, 2'b10, 8'h00, 32'h0, 0, 1);
    step(0, 2'b10, 8'h00, 32'h0, 0, 1);
    chk("pre_rst_data", 32'(bus.data_out), 8'hB8);
    #2 rst_n = 0;
    #1;
    chk("arst_data", 32'(bus.data_out), 0);
    chk("arst_chk", 32'(bus.check_out), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    step(1, 2'b10, 8'h00, 32'h0, 0, 0);
    step(0, 2'b10, 8'h00, 32'h0, 0, 1);
    chk("rst_lfsr_restart", 32'(bus.data_out), 8'h01);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 11) == 0), 2'($urandom), k, $urandom,
           $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_xor_frame_scrambler.md
# mux_xor_frame_scrambler

Parametrised, clocked successor to the single-bit mux-then-XOR cell. It selects one of CHANNELS input words and XORs it with a static key and/or an 8-bit LFSR keystream. It also accumulates a running XOR check over a frame of FRAME_LEN words and emits the check value at frame end. In a Tiny Tapeout slot it sits behind the io_in/io_out wrapper, with io_in[0] as clk and io_in[1] as rst_n.

## Interface
- CHANNELS, 4: number of input channels; power of two, ≥2
- WIDTH, 8: word width, 1..8
- FRAME_LEN, 4: words per frame, ≥1
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new frame and samples mode/key
- mode  input  2  00 pass, 01 XOR key, 10 XOR LFSR, 11 XOR key and LFSR
- key  input  WIDTH  static key; also LFSR seed
- ch_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- ch_sel  input  clog2(CHANNELS)  channel select, sampled per accepted word
- in_valid  input  1  word present this cycle
- data_out  output  WIDTH  processed word (registered)
- out_valid  output  1  data_out valid, one-cycle pulse per word
- check_out  output  WIDTH  frame XOR check
- check_valid  output  1  one-cycle pulse at frame end
- busy  output  1  high while in RUN

## Operation
- Reset values: state=IDLE, data_out=0, out_valid=0, check_out=0, check_valid=0, busy=0, acc=0, count=0, lfsr=8'h01, mode_r=00, key_r=0.
- FSM states are IDLE and RUN.
- start (either state):
  - acc←0, count←0, mode_r←mode, key_r←key.
  - lfsr←{zero-ext key}; if that value is 0, lfsr←8'h01.
  - state→RUN. check_valid←0. check_out is held.
- start has priority over in_valid. A word presented in the start cycle is discarded, with no out_valid. start during RUN aborts the current frame without a check_valid.
- IDLE: in_valid is ignored and all outputs hold (pulses stay 0).
- RUN, in_valid=1 and start=0, the word is accepted:
  - sel = ch_data[ch_sel*WIDTH +: WIDTH]
  - ks = lfsr[WIDTH-1:0]
  - word = sel ^ (mode_r[0] ? key_r : 0) ^ (mode_r[1] ? ks : 0)
  - data_out←word, out_valid←1, acc←acc^word, count←count+1.
  - The LFSR advances once per accepted word in every mode: lfsr←(lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 8'h00).
- Frame end: when count==FRAME_LEN-1 on accept:
  - check_out←acc^word, check_valid←1, state→IDLE, count←0.
  - check_out holds until the next frame end or reset.
- RUN with in_valid=0: nothing changes and pulses are 0.
- busy is 1 exactly while state==RUN.

## Timing
- Latency: 1 cycle. A word accepted at edge N appears on data_out/out_valid after edge N.
- On the final word, data_out, out_valid, check_out and check_valid all assert together after the same edge. busy drops after that edge.
- Back-to-back in_valid gives one word per cycle with no bubbles.
- A new start may arrive in the cycle right after the frame-end pulse; there is no dead cycle.
- FRAME_LEN=1: every frame is one word. check_out equals that word.
- rst_n asserted mid-frame: all state returns to reset values immediately (asynchronously), pulses clear, and the partial frame is lost.
- rst_n deassertion is synchronised by the integration wrapper, not by this block.

## Test plan
All scenarios use CHANNELS=4, WIDTH=8, FRAME_LEN=4.
- Reset then idle: in_valid pulses with no start -> out_valid=0, busy=0, all outputs 0.
- Pass mode: start mode=00, then four words with ch_data={78,56,34,12} (ch3..ch0, hex) and ch_sel=0,1,2,3 -> data_out 12,34,56,78; check_out=0x08 with check_valid on the 4th word.
- Key mode: same stimulus, mode=01, key=FF -> data_out ED,CB,A9,87; check_out=0x08.
- LFSR mode with zero-seed substitution: mode=10, key=00, all inputs 00 -> data_out 01,B8,5C,2E; check_out=0xCB.
- Gapped input and abort:
  - in_valid gaps mid-frame -> no out_valid during gaps and correct final check.
  - start after 2 words -> no check_valid; the next 4 words produce a fresh check.
  - start and in_valid in the same cycle -> that word is dropped.
- Async reset mid-frame: rst_n low after word 2 -> outputs 0 immediately. After release and a new start, the LFSR restarts from its seed: mode 10 output begins at 01 again.
